// File: rtl/wdg_pkg.sv
// Shared constants for the windowed watchdog: state encodings and parameter defaults.
package wdg_pkg;

    localparam int unsigned WDG_CNT_W       = 16;
    localparam int unsigned WDG_STRIKE_W    = 3;
    localparam int unsigned WDG_MAX_STRIKES = 3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CLOSED = 2'd1;
    localparam logic [1:0] ST_OPEN   = 2'd2;
    localparam logic [1:0] ST_FAULT  = 2'd3;

endpackage

// File: rtl/wdg_window_cnt.sv
// Window counter with bounds captured at every window start.
// It flags the last closed count (at_min) and the final legal count (at_max).
module wdg_window_cnt
    import wdg_pkg::*;
#(
    parameter int unsigned CNT_W = WDG_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] win_min_i,
    input  logic [CNT_W-1:0] win_max_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             at_min_o,
    output logic             at_max_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] min_q, min_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] cnt_plus1;

    assign cnt_plus1 = cnt_q + 1'b1;

    always_comb begin
        cnt_d = cnt_q;
        min_d = min_q;
        max_d = max_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            // Bounds are sampled only here, so mid-window input changes wait for the next window.
            cnt_d = '0;
            min_d = win_min_i;
            max_d = win_max_i;
        end else if (inc_i) begin
            cnt_d = cnt_plus1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            min_q <= '0;
            max_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign at_min_o = (cnt_plus1 == min_q);
    assign at_max_o = (cnt_q == max_q);

endmodule

// File: rtl/windowed_watchdog.sv
// Windowed watchdog: early/late service detection, consecutive-strike counting
// and a latched FAULT that only CLR releases.
module windowed_watchdog
    import wdg_pkg::*;
#(
    parameter int unsigned CNT_W       = WDG_CNT_W,
    parameter int unsigned STRIKE_W    = WDG_STRIKE_W,
    parameter int unsigned MAX_STRIKES = WDG_MAX_STRIKES
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                EN,
    input  logic                WDSRVC,
    input  logic [CNT_W-1:0]    WINMIN,
    input  logic [CNT_W-1:0]    WINMAX,
    input  logic                CLR,
    output logic                FWOVR,
    output logic                EARLY,
    output logic                SRVOK,
    output logic                FAULT,
    output logic                CFGERR,
    output logic [STRIKE_W-1:0] STRIKES,
    output logic [CNT_W-1:0]    CNT
);

    localparam logic [STRIKE_W-1:0] STRIKE_LIMIT = MAX_STRIKES[STRIKE_W-1:0];

    logic [1:0]          state_q, state_d;
    logic [STRIKE_W-1:0] strikes_q, strikes_d;
    logic                fwovr_q, fwovr_d;
    logic                early_q, early_d;
    logic                srvok_q, srvok_d;
    logic                fault_q;
    logic                cfgerr_q;

    logic                cfg_bad;
    logic [1:0]          restart_st;
    logic [STRIKE_W-1:0] strike_inc;
    logic                violation;
    logic                cnt_clear, cnt_load, cnt_inc;
    logic                at_min, at_max;

    assign cfg_bad    = (WINMIN > WINMAX);
    assign restart_st = (WINMIN == '0) ? ST_OPEN : ST_CLOSED;
    assign strike_inc = strikes_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        strikes_d = strikes_q;
        fwovr_d   = 1'b0;
        early_d   = 1'b0;
        srvok_d   = 1'b0;
        violation = 1'b0;
        cnt_clear = 1'b0;
        cnt_load  = 1'b0;
        cnt_inc   = 1'b0;

        if (state_q == ST_FAULT) begin
            if (CLR) begin
                state_d   = ST_IDLE;
                strikes_d = '0;
                cnt_clear = 1'b1;
            end
        end else begin
            if (!EN || cfg_bad) begin
                state_d   = ST_IDLE;
                cnt_clear = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_d  = restart_st;
                        cnt_load = 1'b1;
                    end
                    ST_CLOSED: begin
                        if (WDSRVC) begin
                            early_d   = 1'b1;
                            violation = 1'b1;
                        end else begin
                            cnt_inc = 1'b1;
                            if (at_min) state_d = ST_OPEN;
                        end
                    end
                    ST_OPEN: begin
                        if (WDSRVC) begin
                            srvok_d   = 1'b1;
                            strikes_d = '0;
                            state_d   = restart_st;
                            cnt_load  = 1'b1;
                        end else if (at_max) begin
                            fwovr_d   = 1'b1;
                            violation = 1'b1;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            // A same-cycle CLR cancels the strike, so it can never escalate.
            if (violation) begin
                strikes_d = strike_inc;
                if (!CLR && strike_inc == STRIKE_LIMIT) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d  = restart_st;
                    cnt_load = 1'b1;
                end
            end
            if (CLR) strikes_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= ST_IDLE;
            strikes_q <= '0;
            fwovr_q   <= 1'b0;
            early_q   <= 1'b0;
            srvok_q   <= 1'b0;
            fault_q   <= 1'b0;
            cfgerr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            strikes_q <= strikes_d;
            fwovr_q   <= fwovr_d;
            early_q   <= early_d;
            srvok_q   <= srvok_d;
            fault_q   <= (state_d == ST_FAULT);
            cfgerr_q  <= cfg_bad;
        end
    end

    wdg_window_cnt #(
        .CNT_W (CNT_W)
    ) u_window_cnt (
        .clk_i     (CLK),
        .rst_ni    (RSTN),
        .clear_i   (cnt_clear),
        .load_i    (cnt_load),
        .inc_i     (cnt_inc),
        .win_min_i (WINMIN),
        .win_max_i (WINMAX),
        .cnt_o     (CNT),
        .at_min_o  (at_min),
        .at_max_o  (at_max)
    );

    assign FWOVR   = fwovr_q;
    assign EARLY   = early_q;
    assign SRVOK   = srvok_q;
    assign FAULT   = fault_q;
    assign CFGERR  = cfgerr_q;
    assign STRIKES = strikes_q;

endmodule

// File: tb/tb_windowed_watchdog.sv
// Directed vector bench for windowed_watchdog: a table of per-cycle inputs and
// expected registered outputs, plus a hand-written asynchronous reset sequence.
module tb_windowed_watchdog;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        EN;
    logic        WDSRVC;
    logic [15:0] WINMIN;
    logic [15:0] WINMAX;
    logic        CLR;
    logic        FWOVR, EARLY, SRVOK, FAULT, CFGERR;
    logic [2:0]  STRIKES;
    logic [15:0] CNT;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        logic        rstn, en, srvc, clr;
        logic [15:0] mn, mx;
        logic        fw, ea, ok, ft, ce;
        logic [2:0]  stk;
        logic [15:0] cnt;
    } vec_t;

    vec_t vq[$];

    always #5 CLK = ~CLK;

    windowed_watchdog #(
        .CNT_W       (16),
        .STRIKE_W    (3),
        .MAX_STRIKES (3)
    ) dut (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .EN      (EN),
        .WDSRVC  (WDSRVC),
        .WINMIN  (WINMIN),
        .WINMAX  (WINMAX),
        .CLR     (CLR),
        .FWOVR   (FWOVR),
        .EARLY   (EARLY),
        .SRVOK   (SRVOK),
        .FAULT   (FAULT),
        .CFGERR  (CFGERR),
        .STRIKES (STRIKES),
        .CNT     (CNT)
    );

    task automatic add(input string tag, input int rstn, input int en, input int srvc,
                       input int mn, input int mx, input int clr,
                       input int fw, input int ea, input int ok, input int ft, input int ce,
                       input int stk, input int cnt);
        vec_t v;
        v.tag  = tag;
        v.rstn = (rstn != 0);
        v.en   = (en != 0);
        v.srvc = (srvc != 0);
        v.clr  = (clr != 0);
        v.mn   = 16'(mn);
        v.mx   = 16'(mx);
        v.fw   = (fw != 0);
        v.ea   = (ea != 0);
        v.ok   = (ok != 0);
        v.ft   = (ft != 0);
        v.ce   = (ce != 0);
        v.stk  = 3'(stk);
        v.cnt  = 16'(cnt);
        vq.push_back(v);
    endtask

    task automatic check(input string tag, input logic fw, input logic ea, input logic ok,
                         input logic ft, input logic ce, input logic [2:0] stk,
                         input logic [15:0] cnt);
        logic [23:0] got, want;
        got  = {FWOVR, EARLY, SRVOK, FAULT, CFGERR, STRIKES, CNT};
        want = {fw, ea, ok, ft, ce, stk, cnt};
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got fw=%b ea=%b ok=%b ft=%b ce=%b stk=%0d cnt=%0d, want fw=%b ea=%b ok=%b ft=%b ce=%b stk=%0d cnt=%0d",
                     tag, $time, FWOVR, EARLY, SRVOK, FAULT, CFGERR, STRIKES, CNT,
                     fw, ea, ok, ft, ce, stk, cnt);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RSTN   = 1'b0;
        EN     = 1'b0;
        WDSRVC = 1'b0;
        WINMIN = 16'd4;
        WINMAX = 16'd8;
        CLR    = 1'b0;

        // Reset, then a mid-window service at CNT=5.
        add("reset",        0,0,0, 4,8,0, 0,0,0,0,0, 0,0);
        add("reset_hold",   0,0,0, 4,8,0, 0,0,0,0,0, 0,0);
        add("arm",          1,1,0, 4,8,0, 0,0,0,0,0, 0,0);
        for (int c = 1; c <= 5; c++) add("count_a", 1,1,0, 4,8,0, 0,0,0,0,0, 0,c);
        add("srvok_mid",    1,1,1, 4,8,0, 0,0,1,0,0, 0,0);
        for (int c = 1; c <= 2; c++) add("count_b", 1,1,0, 4,8,0, 0,0,0,0,0, 0,c);
        add("early",        1,1,1, 4,8,0, 0,1,0,0,0, 1,0);
        for (int c = 1; c <= 8; c++) add("count_c", 1,1,0, 4,8,0, 0,0,0,0,0, 1,c);
        add("srvok_at_max", 1,1,1, 4,8,0, 0,0,1,0,0, 0,0);

        // Three unserviced windows escalate to FAULT with CNT frozen at WINMAX.
        for (int k = 1; k <= 3; k++) begin
            for (int c = 1; c <= 8; c++) add("count_to", 1,1,0, 4,8,0, 0,0,0,0,0, k-1,c);
            if (k < 3) add("fwovr",       1,1,0, 4,8,0, 1,0,0,0,0, k,0);
            else       add("fwovr_fault", 1,1,0, 4,8,0, 1,0,0,1,0, 3,8);
        end
        add("fault_srvc",   1,1,1, 4,8,0, 0,0,0,1,0, 3,8);
        add("fault_en_low", 1,0,0, 4,8,0, 0,0,0,1,0, 3,8);
        add("clr_fault",    1,1,0, 4,8,1, 0,0,0,0,0, 0,0);
        add("rearm",        1,1,0, 4,8,0, 0,0,0,0,0, 0,0);
        add("count_d",      1,1,0, 4,8,0, 0,0,0,0,0, 0,1);

        // CLR together with a violation: pulse still emitted, strikes cleared.
        add("early_2",      1,1,1, 4,8,0, 0,1,0,0,0, 1,0);
        add("early_clr",    1,1,1, 4,8,1, 0,1,0,0,0, 0,0);
        add("count_e",      1,1,0, 4,8,0, 0,0,0,0,0, 0,1);

        // Bad bounds force IDLE; fixing them starts a fresh window at 0.
        add("cfgerr",       1,1,0, 9,8,0, 0,0,0,0,1, 0,0);
        add("cfgerr_hold",  1,1,0, 9,8,0, 0,0,0,0,1, 0,0);
        add("cfg_fixed",    1,1,0, 2,8,0, 0,0,0,0,0, 0,0);
        for (int c = 1; c <= 3; c++) add("count_f", 1,1,0, 2,8,0, 0,0,0,0,0, 0,c);
        add("en_low_srvc",  1,0,1, 2,8,0, 0,0,0,0,0, 0,0);
        add("rearm_2",      1,1,0, 2,8,0, 0,0,0,0,0, 0,0);

        // Bounds change mid-window is deferred; then a one-cycle window at 3.
        add("latched_1",    1,1,0, 3,3,0, 0,0,0,0,0, 0,1);
        add("latched_2",    1,1,0, 3,3,0, 0,0,0,0,0, 0,2);
        add("srvok_latch",  1,1,1, 3,3,0, 0,0,1,0,0, 0,0);
        for (int c = 1; c <= 3; c++) add("count_g", 1,1,0, 3,3,0, 0,0,0,0,0, 0,c);
        add("fwovr_1cyc",   1,1,0, 3,3,0, 1,0,0,0,0, 1,0);
        for (int c = 1; c <= 3; c++) add("count_h", 1,1,0, 3,3,0, 0,0,0,0,0, 1,c);
        add("srvok_1cyc",   1,1,1, 3,3,0, 0,0,1,0,0, 0,0);

        foreach (vq[i]) begin
            RSTN   = vq[i].rstn;
            EN     = vq[i].en;
            WDSRVC = vq[i].srvc;
            WINMIN = vq[i].mn;
            WINMAX = vq[i].mx;
            CLR    = vq[i].clr;
            tick();
            check(vq[i].tag, vq[i].fw, vq[i].ea, vq[i].ok, vq[i].ft, vq[i].ce,
                  vq[i].stk, vq[i].cnt);
        end

        // Asynchronous reset at CNT=6 with two strikes pending.
        RSTN = 1'b0; EN = 1'b0; WDSRVC = 1'b0; CLR = 1'b0;
        WINMIN = 16'd4; WINMAX = 16'd8;
        tick();
        check("hs_reset", 0,0,0,0,0, 3'd0, 16'd0);
        RSTN = 1'b1; EN = 1'b1;
        tick();
        check("hs_arm", 0,0,0,0,0, 3'd0, 16'd0);
        WDSRVC = 1'b1;
        tick();
        check("hs_early1", 0,1,0,0,0, 3'd1, 16'd0);
        tick();
        check("hs_early2", 0,1,0,0,0, 3'd2, 16'd0);
        WDSRVC = 1'b0;
        repeat (6) tick();
        check("hs_cnt6", 0,0,0,0,0, 3'd2, 16'd6);
        #3 RSTN = 1'b0;
        #1 check("hs_async_rst", 0,0,0,0,0, 3'd0, 16'd0);
        tick();
        RSTN = 1'b1;
        tick();
        check("hs_rearm", 0,0,0,0,0, 3'd0, 16'd0);
        tick();
        check("hs_count", 0,0,0,0,0, 3'd0, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
